axi_master_arbiter: RTL and testbench
=====================================

Name: axi_master_arbiter

Overview:
- Two-master arbiter directly upstream of the CPU-side port of the AXI read/write bridge.
- Merges instruction-fetch (read-only) and load/store (read/write) requests into one single-outstanding transaction stream.
- Drives the bridge's ar_valid/aw_valid/addr/len/size/data inputs and consumes its ready/r_valid/r_data/resp outputs.
- Routes returned data and responses back to the owning master.

Parameters:
- ADDR_W, 64, address width (matches bridge cpu_addr).
- DATA_W, 64, data width (matches bridge cpu_data / cpu_r_data).
- LEN_W, 8, burst-length width; a value of N means N+1 beats.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_len  in  LEN_W  fetch burst length
- if_size  in  2  00=1B 01=2B 10=4B 11=8B
- if_gnt  out  1  one-cycle pulse: request accepted and latched
- if_rvalid  out  1  fetch beat valid
- if_rdata  out  DATA_W  fetch beat data
- if_done  out  1  one-cycle pulse: fetch transaction complete
- if_err  out  1  valid with if_done; any beat had nonzero resp
- ls_req  in  1  load/store request; held until ls_gnt
- ls_we  in  1  1=write, 0=read
- ls_addr  in  ADDR_W  load/store address
- ls_wdata  in  DATA_W  store data
- ls_len  in  LEN_W  burst length; reads only, writes are forced to 0
- ls_size  in  2  transfer size
- ls_gnt  out  1  one-cycle pulse: request accepted and latched
- ls_rvalid  out  1  load beat valid
- ls_rdata  out  DATA_W  load beat data
- ls_done  out  1  one-cycle pulse: load/store complete
- ls_err  out  1  valid with ls_done
- mem_ar_valid  out  1  to bridge cpu_ar_valid
- mem_aw_valid  out  1  to bridge cpu_aw_valid
- mem_addr  out  ADDR_W  to bridge cpu_addr
- mem_len  out  LEN_W  to bridge cpu_len
- mem_size  out  2  to bridge cpu_size
- mem_data  out  DATA_W  to bridge cpu_data
- mem_ar_ready  in  1  from bridge cpu_ar_ready
- mem_aw_ready  in  1  from bridge cpu_aw_ready; one-cycle pulse meaning the write response was received
- mem_r_valid  in  1  from bridge cpu_r_valid
- mem_r_data  in  DATA_W  from bridge cpu_r_data
- mem_resp  in  2  from bridge cpu_resp

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on `reset`.
- Reset values: state IDLE; every valid, gnt, done and err output 0; mem_addr, mem_len, mem_size, mem_data, if_rdata and ls_rdata all 0.
- States: IDLE, RD_ADDR, RD_DATA, WR.
- Owner: a 1-bit register, 0=IF, 1=LS.
- Every mem_* output is driven from a register.
- IDLE:
  - If any req is high, select a winner. Default priority: LS over IF.
  - Latch the winner's addr, len, size and wdata into the mem_* registers. A write forces mem_len=0.
  - Pulse the winner's gnt in the same cycle.
  - Read: go to RD_ADDR with mem_ar_valid=1. Write: go to WR with mem_aw_valid=1.
  - The losing request stays pending with no gnt.
- RD_ADDR:
  - Hold mem_ar_valid and all fields stable until mem_ar_ready=1.
  - Then drop mem_ar_valid, clear the beat counter and the err flag, and go to RD_DATA.
- RD_DATA, on each mem_r_valid:
  - Assert owner rvalid combinationally in the same cycle; rdata = mem_r_data.
  - OR (mem_resp != 0) into the err flag.
  - Increment the beat counter.
  - On the beat where counter == mem_len: pulse owner done next cycle, with owner err = accumulated flag; go to IDLE.
- WR:
  - Hold mem_aw_valid and mem_data until mem_aw_ready=1.
  - Then drop mem_aw_valid and pulse ls_done next cycle, with ls_err = (mem_resp != 0); go to IDLE.
- Turnaround: the next grant is no earlier than the cycle done pulses. Exactly one transaction is outstanding at any time.
- Ignored inputs:
  - mem_r_valid outside RD_DATA.
  - mem_aw_ready outside WR.
  - mem_ar_ready outside RD_ADDR.
- Request inputs are sampled only in IDLE. Changes to addr/data after gnt have no effect.
- Beat counter is LEN_W bits. mem_len = 2^LEN_W - 1 completes at the final beat without wrap error.
- Simultaneous if_req and ls_req in IDLE: LS wins. IF keeps its req and is granted in a later IDLE.
- Reset asserted mid-transaction: immediate return to IDLE next edge, with all valids 0 and no done pulse. The bridge must be reset in the same cycle.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-owner register, reset to IF.
  - On simultaneous requests, the master that was not last granted wins.
  - A single requester always wins.
- Undefined: fixed LS>IF priority; no last-owner register.

Test Plan:
- if_req, addr 0x8000_0000, len 3, size 11; ar_ready after 2 cycles; 4 r_valid beats 0x11..0x44 -> if_gnt at cycle 0; mem_ar_valid high exactly 3 cycles; if_rvalid ×4 with matching data; if_done one cycle after beat 4; if_err=0.
- ls_req we=1, addr 0x8000_0100, wdata 0xDEAD_BEEF, size 10; aw_ready pulse at cycle 5 -> mem_aw_valid cycles 1–5; mem_len=0; ls_done at cycle 6; ls_err=0.
- if_req and ls_req (read) asserted together -> ls_gnt first; if_gnt only after ls_done. With ARB_ROUND_ROBIN_EN and last owner LS, if_gnt first instead.
- Load len 1 with beat 0 resp=10, beat 1 resp=00 -> ls_err=1 with ls_done.
- mem_r_valid pulsed in IDLE and RD_ADDR, mem_aw_ready pulsed during a read -> no rvalid, no done, state unaffected.
- reset asserted during RD_DATA after 1 of 4 beats -> next cycle IDLE; all outputs 0; no done. A fresh if_req afterwards is granted normally.

Source files
------------

// File: rtl/axi_master_arbiter.sv
// Two-master (fetch / load-store) arbiter feeding a single-outstanding AXI bridge port.
// Define ARB_ROUND_ROBIN_EN to alternate priority on contention instead of fixed LS > IF.
module axi_master_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [LEN_W-1:0]  if_len,
  input  logic [1:0]        if_size,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [LEN_W-1:0]  ls_len,
  input  logic [1:0]        ls_size,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_done,
  output logic              ls_err,
  output logic              mem_ar_valid,
  output logic              mem_aw_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LEN_W-1:0]  mem_len,
  output logic [1:0]        mem_size,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_ar_ready,
  input  logic              mem_aw_ready,
  input  logic              mem_r_valid,
  input  logic [DATA_W-1:0] mem_r_data,
  input  logic [1:0]        mem_resp
);

  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, WR} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              ar_valid_q, ar_valid_d;
  logic              aw_valid_q, aw_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [1:0]        size_q, size_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              err_acc_q, err_acc_d;
  logic              if_done_q, if_done_d;
  logic              if_err_q, if_err_d;
  logic              ls_done_q, ls_done_d;
  logic              ls_err_q, ls_err_d;
  logic              win_ls;
  logic              rd_beat;
`ifdef ARB_ROUND_ROBIN_EN
  logic              last_q, last_d;
`endif

  // Winner selection: LS is picked whenever it is the only requester or holds priority.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    win_ls = ls_req & (~if_req | ~last_q);
`else
    win_ls = ls_req;
`endif
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ar_valid_d = ar_valid_q;
    aw_valid_d = aw_valid_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    data_d     = data_q;
    beat_d     = beat_q;
    err_acc_d  = err_acc_q;
    if_done_d  = 1'b0;
    if_err_d   = 1'b0;
    ls_done_d  = 1'b0;
    ls_err_d   = 1'b0;
    if_gnt     = 1'b0;
    ls_gnt     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (if_req || ls_req) begin
          owner_d = win_ls;
          if_gnt  = ~win_ls;
          ls_gnt  = win_ls;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = win_ls;
`endif
          addr_d  = win_ls ? ls_addr : if_addr;
          size_d  = win_ls ? ls_size : if_size;
          data_d  = win_ls ? ls_wdata : '0;
          if (win_ls && ls_we) begin
            len_d      = '0;
            aw_valid_d = 1'b1;
            state_d    = WR;
          end else begin
            len_d      = win_ls ? ls_len : if_len;
            ar_valid_d = 1'b1;
            state_d    = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (mem_ar_ready) begin
          ar_valid_d = 1'b0;
          beat_d     = '0;
          err_acc_d  = 1'b0;
          state_d    = RD_DATA;
        end
      end
      RD_DATA: begin
        if (mem_r_valid) begin
          err_acc_d = err_acc_q | (mem_resp != 2'b00);
          beat_d    = beat_q + 1'b1;
          // Compare before increment so a full 2^LEN_W-beat burst ends cleanly.
          if (beat_q == len_q) begin
            if_done_d = ~owner_q;
            if_err_d  = ~owner_q & err_acc_d;
            ls_done_d = owner_q;
            ls_err_d  = owner_q & err_acc_d;
            state_d   = IDLE;
          end
        end
      end
      WR: begin
        if (mem_aw_ready) begin
          aw_valid_d = 1'b0;
          ls_done_d  = 1'b1;
          ls_err_d   = (mem_resp != 2'b00);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A grant seen during reset would be lost, so never advertise one.
    if (reset) begin
      if_gnt = 1'b0;
      ls_gnt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      ar_valid_q <= 1'b0;
      aw_valid_q <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      data_q     <= '0;
      beat_q     <= '0;
      err_acc_q  <= 1'b0;
      if_done_q  <= 1'b0;
      if_err_q   <= 1'b0;
      ls_done_q  <= 1'b0;
      ls_err_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ar_valid_q <= ar_valid_d;
      aw_valid_q <= aw_valid_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      data_q     <= data_d;
      beat_q     <= beat_d;
      err_acc_q  <= err_acc_d;
      if_done_q  <= if_done_d;
      if_err_q   <= if_err_d;
      ls_done_q  <= ls_done_d;
      ls_err_q   <= ls_err_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  assign rd_beat      = (state_q == RD_DATA) & mem_r_valid;
  assign if_rvalid    = rd_beat & ~owner_q;
  assign ls_rvalid    = rd_beat & owner_q;
  assign if_rdata     = if_rvalid ? mem_r_data : '0;
  assign ls_rdata     = ls_rvalid ? mem_r_data : '0;
  assign if_done      = if_done_q;
  assign if_err       = if_err_q;
  assign ls_done      = ls_done_q;
  assign ls_err       = ls_err_q;
  assign mem_ar_valid = ar_valid_q;
  assign mem_aw_valid = aw_valid_q;
  assign mem_addr     = addr_q;
  assign mem_len      = len_q;
  assign mem_size     = size_q;
  assign mem_data     = data_q;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Bench for axi_master_arbiter: plays the bridge side and checks against a transaction-level model.
module tb_axi_master_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_gnt, if_rvalid, if_done, if_err;
  logic [AW-1:0] if_addr;
  logic [LW-1:0] if_len;
  logic [1:0]    if_size;
  logic [DW-1:0] if_rdata;
  logic          ls_req, ls_we, ls_gnt, ls_rvalid, ls_done, ls_err;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic [LW-1:0] ls_len;
  logic [1:0]    ls_size;
  logic          mem_ar_valid, mem_aw_valid, mem_ar_ready, mem_aw_ready, mem_r_valid;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_len;
  logic [1:0]    mem_size, mem_resp;
  logic [DW-1:0] mem_data, mem_r_data;

  always #5 clk = ~clk;

  axi_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_len(if_len), .if_size(if_size),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_len(ls_len),
    .ls_size(ls_size), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ls_done(ls_done), .ls_err(ls_err),
    .mem_ar_valid(mem_ar_valid), .mem_aw_valid(mem_aw_valid), .mem_addr(mem_addr),
    .mem_len(mem_len), .mem_size(mem_size), .mem_data(mem_data),
    .mem_ar_ready(mem_ar_ready), .mem_aw_ready(mem_aw_ready), .mem_r_valid(mem_r_valid),
    .mem_r_data(mem_r_data), .mem_resp(mem_resp)
  );

  int            n_vec = 0;
  int            n_err = 0;
  logic          last_ls = 1'b0;
  logic          exp_if_done = 1'b0, exp_ls_done = 1'b0, exp_err = 1'b0;
  logic [DW-1:0] bd [256];
  logic [1:0]    br [256];

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_bus();
    mem_ar_ready = 1'b0; mem_aw_ready = 1'b0; mem_r_valid = 1'b0;
    mem_r_data = '0; mem_resp = 2'b00;
  endtask

  task automatic chk_no_resp(input string where);
    chk1({where, "_if_rvalid"}, if_rvalid, 1'b0);
    chk1({where, "_ls_rvalid"}, ls_rvalid, 1'b0);
    chk1({where, "_if_done"}, if_done, 1'b0);
    chk1({where, "_ls_done"}, ls_done, 1'b0);
  endtask

  task automatic chk_all_zero(input string where);
    chk_no_resp(where);
    chk1({where, "_ar_valid"}, mem_ar_valid, 1'b0);
    chk1({where, "_aw_valid"}, mem_aw_valid, 1'b0);
    chkw({where, "_addr"}, mem_addr, '0);
    chkw({where, "_len"}, 64'(mem_len), '0);
    chkw({where, "_size"}, 64'(mem_size), '0);
    chkw({where, "_data"}, mem_data, '0);
    chkw({where, "_if_rdata"}, if_rdata, '0);
    chkw({where, "_ls_rdata"}, ls_rdata, '0);
    chk1({where, "_if_err"}, if_err, 1'b0);
    chk1({where, "_ls_err"}, ls_err, 1'b0);
  endtask

  // Idle-cycle check: previous completion pulses and arbitration among pending requests.
  task automatic top_check(output logic wl);
    logic any;
    #1;
    any = if_req | ls_req;
    if (if_req && ls_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      wl = ~last_ls;
`else
      wl = 1'b1;
`endif
    end else begin
      wl = ls_req;
    end
    chk1("if_gnt", if_gnt, any & ~wl);
    chk1("ls_gnt", ls_gnt, any & wl);
    chk1("if_done", if_done, exp_if_done);
    chk1("ls_done", ls_done, exp_ls_done);
    chk1("if_err", if_err, exp_if_done & exp_err);
    chk1("ls_err", ls_err, exp_ls_done & exp_err);
    chk1("idle_if_rvalid", if_rvalid, 1'b0);
    chk1("idle_ls_rvalid", ls_rvalid, 1'b0);
    exp_if_done = 1'b0; exp_ls_done = 1'b0; exp_err = 1'b0;
    if (any) last_ls = wl;
  endtask

  // One full transaction for whichever master the model says wins; bd/br hold read beats.
  task automatic round(input int dly, input int gap_max, input logic [1:0] wresp);
    logic          wl, e_we, acc;
    logic [AW-1:0] e_a;
    logic [LW-1:0] e_l;
    logic [1:0]    e_s;
    logic [DW-1:0] e_d;
    mem_r_valid  = 1'($urandom_range(0, 1));
    mem_ar_ready = 1'($urandom_range(0, 1));
    mem_aw_ready = 1'($urandom_range(0, 1));
    top_check(wl);
    e_we = wl & ls_we;
    e_a  = wl ? ls_addr : if_addr;
    e_s  = wl ? ls_size : if_size;
    e_l  = e_we ? '0 : (wl ? ls_len : if_len);
    e_d  = ls_wdata;
    tick();
    if (wl) begin
      ls_req = 1'b0; ls_addr = rnd64(); ls_wdata = rnd64(); ls_len = LW'($urandom);
    end else begin
      if_req = 1'b0; if_addr = rnd64(); if_len = LW'($urandom);
    end
    for (int k = 0; k <= dly; k++) begin
      mem_r_valid = 1'($urandom_range(0, 1));
      if (e_we) begin
        mem_aw_ready = (k == dly);
        mem_ar_ready = 1'($urandom_range(0, 1));
        mem_resp     = (k == dly) ? wresp : 2'($urandom);
      end else begin
        mem_ar_ready = (k == dly);
        mem_aw_ready = 1'($urandom_range(0, 1));
      end
      #1;
      chk1("ar_valid", mem_ar_valid, ~e_we);
      chk1("aw_valid", mem_aw_valid, e_we);
      chkw("mem_addr", mem_addr, e_a);
      chkw("mem_len", 64'(mem_len), 64'(e_l));
      chkw("mem_size", 64'(mem_size), 64'(e_s));
      if (e_we) chkw("mem_data", mem_data, e_d);
      chk1("busy_if_gnt", if_gnt, 1'b0);
      chk1("busy_ls_gnt", ls_gnt, 1'b0);
      chk_no_resp("addr_phase");
      tick();
    end
    clear_bus();
    if (e_we) begin
      exp_ls_done = 1'b1;
      exp_err = (wresp != 2'b00);
    end else begin
      acc = 1'b0;
      for (int b = 0; b <= int'(e_l); b++) begin
        repeat ($urandom_range(0, gap_max)) begin
          mem_aw_ready = 1'($urandom_range(0, 1));
          mem_ar_ready = 1'($urandom_range(0, 1));
          #1;
          chk1("data_ar_valid", mem_ar_valid, 1'b0);
          chk_no_resp("gap");
          tick();
        end
        mem_aw_ready = 1'b0; mem_ar_ready = 1'b0;
        mem_r_valid = 1'b1; mem_r_data = bd[b]; mem_resp = br[b];
        #1;
        chk1("beat_if_rvalid", if_rvalid, ~wl);
        chk1("beat_ls_rvalid", ls_rvalid, wl);
        chkw("beat_rdata", wl ? ls_rdata : if_rdata, bd[b]);
        chk1("beat_if_done", if_done, 1'b0);
        chk1("beat_ls_done", ls_done, 1'b0);
        acc = acc | (br[b] != 2'b00);
        tick();
        mem_r_valid = 1'b0;
      end
      clear_bus();
      if (wl) exp_ls_done = 1'b1; else exp_if_done = 1'b1;
      exp_err = acc;
    end
  endtask

  task automatic fill_random();
    for (int b = 0; b < 4; b++) begin
      bd[b] = rnd64();
      br[b] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    end
  endtask

  initial begin
    logic wl;
    reset = 1'b1;
    if_req = 0; if_addr = '0; if_len = '0; if_size = '0;
    ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_len = '0; ls_size = '0;
    clear_bus();
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk_all_zero("reset");
    tick();

    // Fetch burst of 4, ar_ready two cycles after ar_valid rises.
    if_req = 1; if_addr = 64'h8000_0000; if_len = 8'd3; if_size = 2'b11;
    for (int b = 0; b < 4; b++) begin
      bd[b] = 64'(8'h11 * (b + 1)); br[b] = 2'b00;
    end
    round(2, 0, 2'b00);

    // Single store; ls_len is nonzero but must be forced to 0.
    ls_req = 1; ls_we = 1; ls_addr = 64'h8000_0100; ls_wdata = 64'hDEAD_BEEF;
    ls_len = 8'd5; ls_size = 2'b10;
    round(4, 0, 2'b00);

    // Contention: both read; the loser stays pending and is granted next.
    if_req = 1; if_addr = 64'h8000_0040; if_len = 8'd1; if_size = 2'b11;
    ls_req = 1; ls_we = 0; ls_addr = 64'h8000_0200; ls_len = 8'd0; ls_size = 2'b11;
    fill_random();
    br[0] = 2'b00; br[1] = 2'b00;
    round(1, 1, 2'b00);
    round(0, 1, 2'b00);

    // Load with an error on the first beat only.
    ls_req = 1; ls_we = 0; ls_addr = 64'h8000_0300; ls_len = 8'd1; ls_size = 2'b01;
    bd[0] = 64'hA5; br[0] = 2'b10; bd[1] = 64'h5A; br[1] = 2'b00;
    round(0, 0, 2'b00);

    // Store with SLVERR response.
    ls_req = 1; ls_we = 1; ls_addr = 64'h8000_0400; ls_wdata = rnd64(); ls_len = 8'd0;
    round(0, 0, 2'b10);

    // Maximum burst length: 256 beats with no wrap-around.
    if_req = 1; if_addr = 64'h9000_0000; if_len = 8'hFF; if_size = 2'b11;
    for (int b = 0; b < 256; b++) begin
      bd[b] = 64'(b) * 64'h0101_0101_0101_0101; br[b] = 2'b00;
    end
    round(0, 0, 2'b00);

    // Reset during the data phase after one of four beats.
    if_req = 1; if_addr = 64'hA000_0000; if_len = 8'd3; if_size = 2'b11;
    top_check(wl);
    tick();
    if_req = 0; mem_ar_ready = 1;
    #1;
    chk1("rst_ar_valid", mem_ar_valid, 1'b1);
    tick();
    mem_ar_ready = 0; mem_r_valid = 1; mem_r_data = 64'h77;
    #1;
    chk1("rst_beat_rvalid", if_rvalid, 1'b1);
    tick();
    mem_r_valid = 0; reset = 1;
    tick();
    reset = 0; last_ls = 1'b0;
    #1;
    chk_all_zero("midreset");
    mem_r_valid = 1;
    #1;
    chk_no_resp("post_reset_rvalid");
    tick();
    mem_r_valid = 0;
    #1;
    chk_no_resp("post_reset_quiet");
    tick();
    if_req = 1; if_addr = 64'hA000_0100; if_len = 8'd0; if_size = 2'b10;
    bd[0] = 64'hCAFE; br[0] = 2'b00;
    round(1, 0, 2'b00);

    // Randomized mix of requests, lengths, latencies and responses.
    for (int it = 0; it < 40; it++) begin
      if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req = 1; if_addr = rnd64(); if_len = LW'($urandom_range(0, 3)); if_size = 2'($urandom);
      end
      if (!ls_req && $urandom_range(0, 1) == 1) begin
        ls_req = 1; ls_we = 1'($urandom_range(0, 1)); ls_addr = rnd64(); ls_wdata = rnd64();
        ls_len = LW'($urandom_range(0, 3)); ls_size = 2'($urandom);
      end
      if (!if_req && !ls_req) begin
        if_req = 1; if_addr = rnd64(); if_len = LW'($urandom_range(0, 3)); if_size = 2'($urandom);
      end
      fill_random();
      round($urandom_range(0, 3), 2, ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00);
    end

    top_check(wl);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
